toggle_edge_counter: RTL and testbench
======================================

// Module: toggle_edge_counter
// PURPOSE
//  Stage directly downstream of t_ff. Samples the t_ff q output and counts its edges over
//  fixed windows of WIN clocks. Presents each window total on a valid/ready output port.
//  Flags saturation and overrun. Used to measure toggle rate/activity of t_ff chains.
// PARAMETERS
//  CNT_W      8   width of edge count and of out_count
//  WIN        16  window length in clk cycles, >=2
//  EDGE_MODE  0   0 = count both edges of q_in, 1 = count rising edges only
// PORTS
//  clk        in   1      single clock, all logic on posedge
//  rst        in   1      asynchronous, active-low reset (0 = reset)
//  en         in   1      1 = measure, 0 = idle
//  clr        in   1      sync clear: counters, out_valid, overrun -> 0 (priority over all but rst)
//  q_in       in   1      q output of t_ff
//  out_valid  out  1      window result available
//  out_ready  in   1      consumer accepts result
//  out_count  out  CNT_W  edges in completed window
//  out_sat    out  1      out_count saturated in that window
//  overrun    out  1      sticky: a window result was dropped
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, edge_cnt=0, win_cnt=0, q_d=0.
//   All outputs 0: out_valid, out_count, out_sat, overrun.
//  FSM: IDLE -(en=1)-> PRIME -> RUN. Any state -(en=0)-> IDLE. clr: any state -> IDLE if en=0, else PRIME.
//  IDLE: edge_cnt, win_cnt held at 0. Output register and out_valid keep their values (handshake still works).
//  PRIME: one cycle; q_d <= q_s. No edge counted, win_cnt stays 0. Avoids false edge after reset/enable.
//  RUN: edge = (q_s ^ q_d) for EDGE_MODE=0, (q_s & ~q_d) for EDGE_MODE=1; q_d <= q_s every cycle.
//   - Edge is counted in the cycle it is visible on q_s.
//   - edge_cnt saturates at 2^CNT_W-1; sat_flag is set if an increment is attempted at max.
//   - win_cnt counts 0..WIN-1. At win_cnt==WIN-1 (window end):
//       result = edge_cnt + edge (saturating); edge_cnt <= 0; win_cnt <= 0; sat_flag <= 0.
//  Output port:
//   - Window end with out_valid=0, or with out_valid=1 & out_ready=1 in the same cycle:
//       load out_count/out_sat from the new result; out_valid <= 1.
//   - Window end with out_valid=1 & out_ready=0: keep old data, drop the new result, overrun <= 1.
//   - out_valid=1 & out_ready=1 with no window end: out_valid <= 0 next cycle.
//   - out_count and out_sat are stable while out_valid=1 & out_ready=0.
//  Latency: window result is valid on the clock after the window-end cycle.
//   q_in to q_s is 0 cycles without sync, 2 cycles with sync.
//  overrun: cleared only by rst or clr.
//  en dropped mid-window: partial count discarded, no result produced.
// CONFIGURATION
//  TOGGLE_CNT_SYNC_EN defined: q_in passes through a 2-flop synchronizer (reset to 0) to form q_s.
//   Use when q_in comes from another clock or an async source.
//  Not defined: q_s = q_in directly. q_in must be synchronous to clk (normal t_ff case).
// STRUCTURE
//  Shared header toggle_cnt_defs.vh: FSM state encodings (ST_IDLE=2'd0, ST_PRIME=2'd1, ST_RUN=2'd2)
//   and EDGE_BOTH=0 / EDGE_RISE=1 constants.
//  One sub-module, tec_edge_detect: optional synchronizer plus q_d register plus edge logic.
//   Outputs a 1-cycle edge strobe.
//  Top level holds the FSM, edge/window counters and the output register with handshake.
// TESTING (bench instantiates t_ff -> toggle_edge_counter on the same clk)
//  1. rst=0 then 1, en=1, t=1 constant, WIN=16, EDGE_MODE=0, out_ready=1
//     -> every window out_count=16, out_sat=0, overrun=0.
//  2. Same as 1 with EDGE_MODE=1 -> out_count=8 per window.
//  3. CNT_W=3, t=1, WIN=16 -> out_count=7, out_sat=1. Next window also 7/1, so sat_flag cleared and re-set.
//  4. out_ready=0 across two window ends -> first result held, overrun=1.
//     Then out_ready=1 for 1 cycle -> out_valid=0. Then clr -> overrun=0.
//  5. out_ready=1 exactly in a window-end cycle -> new count loaded, out_valid stays 1, overrun=0.
//  6. t=0 (q static), en toggled 0->1 with q=1 -> PRIME gives no false edge, out_count=0.
//     Async rst pulse mid-window -> all outputs 0 immediately.

Source files
------------

// File: rtl/toggle_edge_counter_pkg.sv
// Shared definitions for toggle_edge_counter: FSM state encoding and edge-mode constants.
package toggle_edge_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam int EDGE_BOTH = 0;
    localparam int EDGE_RISE = 1;

endpackage

// File: rtl/toggle_edge_counter_edge_detect.sv
// Edge detector for toggle_edge_counter: optional 2-flop synchronizer (TOGGLE_CNT_SYNC_EN),
// previous-sample register and combinational edge strobe.
module tec_edge_detect
    import toggle_edge_counter_pkg::*;
#(
    parameter int EDGE_MODE = EDGE_BOTH
) (
    input  logic clk,
    input  logic rst,
    input  logic q_in,
    input  logic load,
    output logic edge_pulse
);

    logic q_s;
    logic q_d_reg;

`ifdef TOGGLE_CNT_SYNC_EN
    logic [1:0] sync_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], q_in};
        end
    end

    assign q_s = sync_reg[1];
`else
    assign q_s = q_in;
`endif

    // q_d only follows q_s while priming or running, so a fresh enable never sees a stale edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_d_reg <= 1'b0;
        end else if (load) begin
            q_d_reg <= q_s;
        end
    end

    generate
        if (EDGE_MODE == EDGE_RISE) begin : g_rise
            assign edge_pulse = q_s & ~q_d_reg;
        end else begin : g_both
            assign edge_pulse = q_s ^ q_d_reg;
        end
    endgenerate

endmodule

// File: rtl/toggle_edge_counter.sv
// Counts t_ff output edges over fixed WIN-cycle windows and presents each total on a
// valid/ready port with saturation and overrun flags. Optional macro: TOGGLE_CNT_SYNC_EN.
module toggle_edge_counter
    import toggle_edge_counter_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int WIN       = 16,
    parameter int EDGE_MODE = EDGE_BOTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             q_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat,
    output logic             overrun
);

    localparam int WIN_W = (WIN > 2) ? $clog2(WIN) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN - 1);

    state_t state_reg;
    state_t state_next;

    logic [CNT_W-1:0] edge_cnt_reg;
    logic [WIN_W-1:0] win_cnt_reg;
    logic             sat_flag_reg;

    logic             out_valid_reg;
    logic [CNT_W-1:0] out_count_reg;
    logic             out_sat_reg;
    logic             overrun_reg;

    logic             edge_pulse;
    logic             counting;
    logic             edge_hit;
    logic             at_max;
    logic             win_end;
    logic [CNT_W-1:0] result_count;
    logic             result_sat;

    tec_edge_detect #(
        .EDGE_MODE (EDGE_MODE)
    ) u_edge_detect (
        .clk        (clk),
        .rst        (rst),
        .q_in       (q_in),
        .load       ((state_reg == ST_PRIME) || (state_reg == ST_RUN)),
        .edge_pulse (edge_pulse)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (clr) begin
            state_next = en ? ST_PRIME : ST_IDLE;
        end else if (!en) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:  state_next = ST_PRIME;
                ST_PRIME: state_next = ST_RUN;
                ST_RUN:   state_next = ST_RUN;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // A cycle only contributes to a window if measurement continues past it
    assign counting     = (state_reg == ST_RUN) && en && !clr;
    assign edge_hit     = counting && edge_pulse;
    assign at_max       = (edge_cnt_reg == {CNT_W{1'b1}});
    assign win_end      = counting && (win_cnt_reg == WIN_LAST);
    assign result_count = (edge_hit && !at_max) ? edge_cnt_reg + CNT_W'(1) : edge_cnt_reg;
    assign result_sat   = sat_flag_reg | (edge_hit & at_max);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt_reg <= '0;
            win_cnt_reg  <= '0;
            sat_flag_reg <= 1'b0;
        end else if (!counting || win_end) begin
            edge_cnt_reg <= '0;
            win_cnt_reg  <= '0;
            sat_flag_reg <= 1'b0;
        end else begin
            edge_cnt_reg <= result_count;
            win_cnt_reg  <= win_cnt_reg + WIN_W'(1);
            sat_flag_reg <= result_sat;
        end
    end

    // A new result is dropped (not queued) when the previous one is still pending
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_reg <= 1'b0;
            out_count_reg <= '0;
            out_sat_reg   <= 1'b0;
            overrun_reg   <= 1'b0;
        end else if (clr) begin
            out_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else if (win_end) begin
            if (!out_valid_reg || out_ready) begin
                out_valid_reg <= 1'b1;
                out_count_reg <= result_count;
                out_sat_reg   <= result_sat;
            end else begin
                overrun_reg   <= 1'b1;
            end
        end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_count = out_count_reg;
    assign out_sat   = out_sat_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_toggle_edge_counter.sv
// Bench: a t_ff drives three toggle_edge_counter instances (both-edge, rise-only, 3-bit count)
// which are compared every cycle against a sample-list model of windowed edge counting.
module tb_toggle_edge_counter;

    localparam int WIN = 16;
    localparam int NI  = 3;

    int cw[NI]   = '{8, 8, 3};
    int mode[NI] = '{0, 1, 0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic clr = 1'b0;
    logic t = 1'b0;
    logic q = 1'b0;
    logic out_ready = 1'b0;

    logic       v[NI];
    logic       s[NI];
    logic       o[NI];
    logic [7:0] c[NI];
    logic [7:0] c0;
    logic [7:0] c1;
    logic [2:0] c2;

    int checks = 0;
    int fails  = 0;

    // model state
    bit         samp[$];
    bit         armed = 1'b0;
    bit         mv[NI] = '{default: 1'b0};
    bit         ms[NI] = '{default: 1'b0};
    bit         mo[NI] = '{default: 1'b0};
    logic [7:0] mc[NI] = '{default: 8'd0};

    always #5 clk = ~clk;

    // t_ff feeding the counters
    always @(posedge clk or negedge rst) begin
        if (!rst) q <= 1'b0;
        else if (t) q <= ~q;
    end

    toggle_edge_counter #(.CNT_W(8), .WIN(WIN), .EDGE_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .q_in(q), .out_valid(v[0]),
        .out_ready(out_ready), .out_count(c0), .out_sat(s[0]), .overrun(o[0]));
    toggle_edge_counter #(.CNT_W(8), .WIN(WIN), .EDGE_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .q_in(q), .out_valid(v[1]),
        .out_ready(out_ready), .out_count(c1), .out_sat(s[1]), .overrun(o[1]));
    toggle_edge_counter #(.CNT_W(3), .WIN(WIN), .EDGE_MODE(0)) dut2 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .q_in(q), .out_valid(v[2]),
        .out_ready(out_ready), .out_count(c2), .out_sat(s[2]), .overrun(o[2]));

    assign c[0] = c0;
    assign c[1] = c1;
    assign c[2] = {5'd0, c2};

    // Reference: collect q samples (first one is the priming reference), count edges between
    // consecutive samples once WIN+1 are held, then run the valid/ready bookkeeping.
    always @(posedge clk or negedge rst) begin
        bit done;
        bit last;
        int n;
        int maxv;
        if (!rst) begin
            samp.delete();
            armed = 1'b0;
            for (int i = 0; i < NI; i++) begin
                mv[i] = 1'b0; ms[i] = 1'b0; mo[i] = 1'b0; mc[i] = 8'd0;
            end
        end else begin
            done = 1'b0;
            if (clr) begin
                samp.delete();
                armed = en;
            end else if (!en) begin
                samp.delete();
                armed = 1'b0;
            end else begin
                if (armed) begin
                    samp.push_back(q);
                    if (samp.size() == WIN + 1) done = 1'b1;
                end
                armed = 1'b1;
            end
            for (int i = 0; i < NI; i++) begin
                if (clr) begin
                    mv[i] = 1'b0;
                    mo[i] = 1'b0;
                end else if (done) begin
                    n = 0;
                    for (int k = 1; k <= WIN; k++) begin
                        if (mode[i] == 0 ? (samp[k-1] != samp[k]) : (!samp[k-1] && samp[k])) n++;
                    end
                    maxv = (1 << cw[i]) - 1;
                    if (!mv[i] || out_ready) begin
                        mc[i] = (n > maxv) ? 8'(maxv) : 8'(n);
                        ms[i] = (n > maxv);
                        mv[i] = 1'b1;
                    end else begin
                        mo[i] = 1'b1;
                    end
                end else if (mv[i] && out_ready) begin
                    mv[i] = 1'b0;
                end
            end
            if (done) begin
                last = samp[$];
                samp.delete();
                samp.push_back(last);
            end
        end
    end

    task automatic test_reset();
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if ({v[i], c[i], s[i], o[i]} !== 11'd0) begin
                fails++;
                $display("FAIL reset dut%0d: got v=%b c=%0d s=%b o=%b, expected all 0", i, v[i], c[i], s[i], o[i]);
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_steady(input int cycles);
        int seen = 0;
        t = 1'b1; out_ready = 1'b1; en = 1'b1; clr = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                checks++;
                if ({v[i], c[i], s[i], o[i]} !== {mv[i], mc[i], ms[i], mo[i]}) begin
                    fails++;
                    $display("FAIL steady_model dut%0d cyc%0d: got v=%b c=%0d s=%b o=%b, expected v=%b c=%0d s=%b o=%b",
                             i, k, v[i], c[i], s[i], o[i], mv[i], mc[i], ms[i], mo[i]);
                end
            end
            if (v[0] === 1'b1) begin
                seen++;
                checks++;
                if ({c[0], s[0], c[1], s[1], c[2], s[2], o[0]} !== {8'd16, 1'b0, 8'd8, 1'b0, 8'd7, 1'b1, 1'b0}) begin
                    fails++;
                    $display("FAIL steady_counts: got %0d/%b %0d/%b %0d/%b ovr=%b, expected 16/0 8/0 7/1 ovr=0",
                             c[0], s[0], c[1], s[1], c[2], s[2], o[0]);
                end
            end
        end
        checks++;
        if (seen < (cycles - 2) / WIN) begin
            fails++;
            $display("FAIL steady_windows: got %0d results, expected %0d", seen, (cycles - 2) / WIN);
        end
    endtask

    task automatic test_overrun();
        int b;
        out_ready = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                checks++;
                if ({v[i], c[i], s[i], o[i]} !== {mv[i], mc[i], ms[i], mo[i]}) begin
                    fails++;
                    $display("FAIL overrun_model dut%0d cyc%0d: got v=%b c=%0d s=%b o=%b, expected v=%b c=%0d s=%b o=%b",
                             i, k, v[i], c[i], s[i], o[i], mv[i], mc[i], ms[i], mo[i]);
                end
            end
        end
        checks++;
        if ({v[0], c[0], o[0]} !== {1'b1, 8'd16, 1'b1}) begin
            fails++;
            $display("FAIL overrun_held: got v=%b c=%0d o=%b, expected v=1 c=16 o=1", v[0], c[0], o[0]);
        end
        b = 0;
        while (samp.size() != 2 && b < 40) begin @(negedge clk); b++; end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if ({v[0], o[0]} !== 2'b01) begin
            fails++;
            $display("FAIL overrun_drain: got v=%b o=%b, expected v=0 o=1", v[0], o[0]);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if ({v[0], o[0], v[2], o[2]} !== 4'b0000) begin
            fails++;
            $display("FAIL overrun_clr: got v=%b o=%b v2=%b o2=%b, expected all 0", v[0], o[0], v[2], o[2]);
        end
    endtask

    task automatic test_ready_at_end();
        int b = 0;
        out_ready = 1'b0;
        while (v[0] !== 1'b1 && b < 40) begin @(negedge clk); b++; end
        checks++;
        if (v[0] !== 1'b1) begin
            fails++;
            $display("FAIL ready_end_first: got v=%b, expected 1 within 40 cycles", v[0]);
        end
        b = 0;
        while (samp.size() != WIN && b < 40) begin @(negedge clk); b++; end
        out_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if ({v[i], c[i], s[i], o[i]} !== {mv[i], mc[i], ms[i], mo[i]}) begin
                fails++;
                $display("FAIL ready_end_model dut%0d: got v=%b c=%0d s=%b o=%b, expected v=%b c=%0d s=%b o=%b",
                         i, v[i], c[i], s[i], o[i], mv[i], mc[i], ms[i], mo[i]);
            end
        end
        checks++;
        if ({v[0], c[0], o[0], v[1], c[1]} !== {1'b1, 8'd16, 1'b0, 1'b1, 8'd8}) begin
            fails++;
            $display("FAIL ready_end_load: got v=%b c=%0d o=%b c1=%0d, expected v=1 c=16 o=0 c1=8", v[0], c[0], o[0], c[1]);
        end
    endtask

    task automatic test_prime();
        int b = 0;
        int seen = 0;
        en = 1'b0; out_ready = 1'b1; t = 1'b1;
        while (q !== 1'b1 && b < 4) begin @(negedge clk); b++; end
        t = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 20) out_ready = 1'b0;
            for (int i = 0; i < NI; i++) begin
                checks++;
                if ({v[i], c[i], s[i], o[i]} !== {mv[i], mc[i], ms[i], mo[i]}) begin
                    fails++;
                    $display("FAIL prime_model dut%0d cyc%0d: got v=%b c=%0d s=%b o=%b, expected v=%b c=%0d s=%b o=%b",
                             i, k, v[i], c[i], s[i], o[i], mv[i], mc[i], ms[i], mo[i]);
                end
            end
            if (v[0] === 1'b1) begin
                seen++;
                checks++;
                if ({c[0], c[1], c[2], s[0]} !== 25'd0) begin
                    fails++;
                    $display("FAIL prime_zero: got %0d %0d %0d s=%b, expected 0 0 0 s=0", c[0], c[1], c[2], s[0]);
                end
            end
        end
        checks++;
        if (seen == 0) begin
            fails++;
            $display("FAIL prime_result: got no result, expected at least one");
        end
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if ({v[i], c[i], s[i], o[i]} !== 11'd0) begin
                fails++;
                $display("FAIL async_reset dut%0d: got v=%b c=%0d s=%b o=%b, expected all 0", i, v[i], c[i], s[i], o[i]);
            end
        end
        #1 rst = 1'b1;
    endtask

    task automatic test_random(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                checks++;
                if ({v[i], c[i], s[i], o[i]} !== {mv[i], mc[i], ms[i], mo[i]}) begin
                    fails++;
                    $display("FAIL random_model dut%0d cyc%0d: got v=%b c=%0d s=%b o=%b, expected v=%b c=%0d s=%b o=%b",
                             i, k, v[i], c[i], s[i], o[i], mv[i], mc[i], ms[i], mo[i]);
                end
            end
            t         = ($urandom_range(0, 3) != 0);
            en        = ($urandom_range(0, 79) != 0);
            clr       = ($urandom_range(0, 249) == 0);
            out_ready = ((k / 64) % 3 == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    endtask

    initial begin
        test_reset();
        test_steady(70);
        test_overrun();
        test_ready_at_end();
        test_prime();
        test_random(3000);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
